// File: rtl/press_arbiter.sv
// press_arbiter
//   Round-robin scheduler sharing the single press input of the press-counter
//   FSM among N_REQ button requesters. Each grant issues one PULSE_LEN-cycle
//   press, then watches the FSM count/err outputs for a response, reports the
//   outcome, and enforces a GAP_LEN-cycle recovery gap before re-arbitrating.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_req        level requests, one bit per requester
//   i_fsm_count  FSM count output
//   i_fsm_err    FSM err output
//   o_press      drives the FSM press input
//   o_grant      one-hot grant, zero when not serving
//   o_busy       high whenever not idle
//   o_done       one-cycle pulse when the response window closes
//   o_result     outcome valid with o_done: 01 ok, 10 fsm error, 11 timeout
//   o_last_id    index of the most recently granted requester
module press_arbiter #(
    parameter int N_REQ     = 4,
    parameter int PULSE_LEN = 2,
    parameter int WAIT_MAX  = 16,
    parameter int GAP_LEN   = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [7:0]                 i_fsm_count,
    input  logic [7:0]                 i_fsm_err,
    output logic                       o_press,
    output logic [N_REQ-1:0]           o_grant,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [1:0]                 o_result,
    output logic [$clog2(N_REQ)-1:0]   o_last_id
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int PW   = $clog2(PULSE_LEN + 1);
    localparam int WW   = $clog2(WAIT_MAX + 1);
    localparam int GW   = $clog2(GAP_LEN + 1);

    localparam logic [ID_W:0]   N_EXT      = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_IDX   = ID_W'(N_REQ - 1);
    localparam logic [PW-1:0]   PULSE_LAST = PW'(PULSE_LEN - 1);
    localparam logic [WW-1:0]   WAIT_LAST  = WW'(WAIT_MAX - 1);
    localparam logic [GW-1:0]   GAP_LAST   = GW'(GAP_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]        r_state;
    logic              r_press;
    logic [N_REQ-1:0]  r_grant;
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_result;
    logic [ID_W-1:0]   r_last_id;
    logic [ID_W-1:0]   r_ptr;
    logic [7:0]        r_cnt_snap;
    logic [7:0]        r_err_snap;
    logic [PW-1:0]     r_pulse_cnt;
    logic [WW-1:0]     r_wait_cnt;
    logic [GW-1:0]     r_gap_cnt;

    // Requests rotated so that bit 0 is the requester at the pointer; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    logic [ID_W:0]     w_rsum [N_REQ];
    logic [ID_W-1:0]   w_ridx [N_REQ];
    logic [N_REQ-1:0]  w_rot;
    logic [N_REQ-1:0]  w_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign w_rsum[gi] = {1'b0, r_ptr} + (ID_W + 1)'(gi);
            assign w_ridx[gi] = (w_rsum[gi] >= N_EXT) ? ID_W'(w_rsum[gi] - N_EXT)
                                                      : w_rsum[gi][ID_W-1:0];
            assign w_rot[gi]  = i_req[w_ridx[gi]];
        end
    endgenerate

    logic [ID_W-1:0] w_off;
    logic            w_found;
    always_comb begin
        w_off   = '0;
        w_found = 1'b0;
        // Descending scan: the last hit is the lowest offset, i.e. nearest to ptr.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off   = ID_W'(k);
                w_found = 1'b1;
            end
        end
    end

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_sel;
    logic [ID_W-1:0] w_ptr_next;
    assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_sel      = (w_sum >= N_EXT) ? ID_W'(w_sum - N_EXT) : w_sum[ID_W-1:0];
    assign w_ptr_next = (w_sel == LAST_IDX) ? '0 : w_sel + 1'b1;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign w_onehot[gi] = (w_sel == ID_W'(gi));
        end
    endgenerate

    // Response classification; error outranks a count change, which outranks timeout.
    logic w_err_hit, w_cnt_hit, w_timeout;
    assign w_err_hit = (i_fsm_err != r_err_snap);
    assign w_cnt_hit = (i_fsm_count != r_cnt_snap);
    assign w_timeout = (r_wait_cnt == WAIT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_press     <= 1'b0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= 2'b00;
            r_last_id   <= '0;
            r_ptr       <= '0;
            r_cnt_snap  <= 8'h00;
            r_err_snap  <= 8'h00;
            r_pulse_cnt <= '0;
            r_wait_cnt  <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_onehot;
                        r_last_id   <= w_sel;
                        r_ptr       <= w_ptr_next;
                        r_press     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cnt_snap  <= i_fsm_count;
                        r_err_snap  <= i_fsm_err;
                        r_pulse_cnt <= '0;
                        r_state     <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (r_pulse_cnt == PULSE_LAST) begin
                        r_press    <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_err_hit || w_cnt_hit || w_timeout) begin
                        r_done    <= 1'b1;
                        r_grant   <= '0;
                        r_result  <= w_err_hit ? 2'b10 : (w_cnt_hit ? 2'b01 : 2'b11);
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_press   = r_press;
    assign o_grant   = r_grant;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_result  = r_result;
    assign o_last_id = r_last_id;

endmodule

// File: tb/tb_press_arbiter.sv
// tb_press_arbiter
//   Directed bench for press_arbiter: expected grant/id/result/latency for each
//   transaction is queued when the request is driven and popped at done.
module tb_press_arbiter;

    localparam int N_REQ     = 4;
    localparam int PULSE_LEN = 2;
    localparam int WAIT_MAX  = 16;
    localparam int GAP_LEN   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] fsm_count;
    logic [7:0] fsm_err;
    logic       press;
    logic [3:0] grant;
    logic       busy;
    logic       done;
    logic [1:0] result;
    logic [1:0] last_id;

    always #5 clk = ~clk;

    press_arbiter #(
        .N_REQ     (N_REQ),
        .PULSE_LEN (PULSE_LEN),
        .WAIT_MAX  (WAIT_MAX),
        .GAP_LEN   (GAP_LEN)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_fsm_count (fsm_count),
        .i_fsm_err   (fsm_err),
        .o_press     (press),
        .o_grant     (grant),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result),
        .o_last_id   (last_id)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] id;
        logic [1:0] res;
        int         lat;
    } exp_t;

    exp_t sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction: request, pulse, response after d WAIT cycles
    // (or none when chg=0), done, gap.
    task automatic txn(input logic [3:0] req_v, input int d, input bit chg,
                       input logic [7:0] cnt_new, input logic [7:0] err_new,
                       input logic [3:0] eg, input logic [1:0] eid, input logic [1:0] eres);
        exp_t e;
        int   n;
        bit   seen;
        e.grant = eg;
        e.id    = eid;
        e.res   = eres;
        e.lat   = chg ? d + 1 : WAIT_MAX;
        sb.push_back(e);
        req  = req_v;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = (press === 1'b1);
        end
        check("press_seen", 32'(seen), 32'd1);
        check("grant", 32'(grant), 32'(sb[0].grant));
        check("last_id", 32'(last_id), 32'(sb[0].id));
        check("busy", 32'(busy), 32'd1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (press !== 1'b1) break;
        end
        check("press_len", 32'(n), 32'(PULSE_LEN));
        check("grant_in_wait", 32'(grant), 32'(sb[0].grant));
        for (int i = 0; i < d; i++) tick();
        if (chg) begin
            fsm_count = cnt_new;
            fsm_err   = err_new;
        end
        n    = d;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            n++;
            seen = (done === 1'b1);
        end
        e = sb.pop_front();
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(e.lat));
        check("result", 32'(result), 32'(e.res));
        check("grant_cleared", 32'(grant), 32'd0);
        check("busy_in_gap", 32'(busy), 32'd1);
        $display("txn req=%b grant=%b id=%0d result=%b latency=%0d", req_v, e.grant, e.id, result, n);
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            n++;
            if (n == 1) check("done_one_cycle", 32'(done), 32'd0);
            seen = (busy === 1'b0);
        end
        check("gap_len", 32'(n), 32'(GAP_LEN));
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        fsm_count = 8'h05;
        fsm_err   = 8'h00;
        tick();
        tick();
        check("rst_press", 32'(press), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_last_id", 32'(last_id), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_press", 32'(press), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Single request, count 5->6 two cycles into WAIT
        txn(4'b0010, 2, 1'b1, 8'h06, 8'h00, 4'b0010, 2'd1, 2'b01);

        // Round robin from pointer 2 with all requests held
        txn(4'b1111, 0, 1'b1, 8'h07, 8'h00, 4'b0100, 2'd2, 2'b01);
        txn(4'b1111, 0, 1'b1, 8'h08, 8'h00, 4'b1000, 2'd3, 2'b01);
        txn(4'b1111, 0, 1'b1, 8'h09, 8'h00, 4'b0001, 2'd0, 2'b01);
        txn(4'b1001, 0, 1'b1, 8'h0A, 8'h00, 4'b1000, 2'd3, 2'b01);
        txn(4'b1111, 0, 1'b1, 8'h0B, 8'h00, 4'b0001, 2'd0, 2'b01);

        // Error outranks a simultaneous count change
        req = 4'b0000;
        tick();
        fsm_count = 8'h03;
        fsm_err   = 8'h00;
        tick();
        txn(4'b0001, 1, 1'b1, 8'h04, 8'h01, 4'b0001, 2'd0, 2'b10);

        // Timeout with no FSM response
        req = 4'b0000;
        tick();
        txn(4'b0001, 0, 1'b0, 8'h00, 8'h00, 4'b0001, 2'd0, 2'b11);

        // Count wrap FF->00 counts as a change
        req = 4'b0000;
        fsm_count = 8'hFF;
        tick();
        txn(4'b1000, 0, 1'b1, 8'h00, 8'h01, 4'b1000, 2'd3, 2'b01);

        // Asynchronous reset during PULSE
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        check("pre_rst_press", 32'(press), 32'd1);
        check("pre_rst_grant", 32'(grant), 32'b0100);
        #2;
        rst = 1'b1;
        #1;
        check("async_press", 32'(press), 32'd0);
        check("async_grant", 32'(grant), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_last_id", 32'(last_id), 32'd0);
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_press", 32'(press), 32'd0);
        end
        txn(4'b1111, 0, 1'b1, 8'h01, 8'h01, 4'b0001, 2'd0, 2'b01);
        req = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/press_arbiter.md
# press_arbiter

Round-robin scheduler that shares the single `press` input of the press-counter FSM (`count[7:0]`, `err[7:0]` outputs) among `N_REQ` button requesters. Each grant issues one fixed-width press pulse to the FSM. The arbiter then watches the FSM's `count`/`err` outputs for acknowledgement, reports the outcome to the granted requester, and enforces a recovery gap before the next grant. It sits between the button-conditioning logic and the FSM instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `PULSE_LEN`, 2: cycles `press` is held high per grant (>=1).
- `WAIT_MAX`, 16: cycles allowed for the FSM to respond before timeout (>=1).
- `GAP_LEN`, 3: idle cycles after each transaction before re-arbitration (>=1).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  level requests, one per requester.
- `fsm_count`  in  8  FSM `count` output.
- `fsm_err`  in  8  FSM `err` output.
- `press`  out  1  drives FSM `press`.
- `grant`  out  N_REQ  one-hot grant; zero when not serving.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at end of WAIT.
- `result`  out  2  outcome, valid with `done`: 01 ok, 10 fsm error, 11 timeout.
- `last_id`  out  $clog2(N_REQ)  index of most recently granted requester.

## Operation
- States: IDLE, PULSE, WAIT, GAP. All outputs are registered.
- Reset (async, immediate): state IDLE; `press`, `grant`, `busy`, `done`, `result`, `last_id` = 0; round-robin pointer `ptr` = 0.
- IDLE: if `req` != 0, select the first set bit scanning from `ptr` upward with wrap. On that edge:
  - `grant` <= one-hot(sel); `last_id` <= sel; `ptr` <= (sel+1) mod N_REQ.
  - `press` <= 1; `busy` <= 1.
  - Snapshot `fsm_count` -> `cnt_snap`, `fsm_err` -> `err_snap`.
  - Go to PULSE.
- PULSE: hold `press`=1 for exactly PULSE_LEN cycles, then `press` <= 0 and go to WAIT with wait counter = 0.
- WAIT: `press`=0, `grant` still held. Each cycle, in priority order:
  1. `fsm_err` != `err_snap` -> `result`=10.
  2. Else `fsm_count` != `cnt_snap` -> `result`=01.
  3. Else wait counter == WAIT_MAX-1 -> `result`=11.
  4. Else increment the wait counter.
  - On outcomes 1-3: `done` pulses, `grant` <= 0, go to GAP.
- GAP: GAP_LEN cycles with `press`=0, `grant`=0, `busy`=1, then IDLE (`busy` <= 0).
- Requests are sampled only in IDLE. Deasserting `req` mid-transaction does not abort it. Requests raised during a transaction wait for the next IDLE.
- Any inequality counts as a count change, including wrap 8'hFF->8'h00 and a decrement.
- Changes on `fsm_count`/`fsm_err` during PULSE are ignored. Only WAIT compares against the snapshot.

## Timing
- Request to press: `req` high before edge E in IDLE -> `press`, `grant`, `busy` high after E.
- `press` is high for edges E+1..E+PULSE_LEN, low after edge E+PULSE_LEN.
- Earliest `done`: one cycle after entering WAIT, i.e. visible after edge E+PULSE_LEN+1 when the FSM responded by then.
- Timeout `done` is visible after edge E+PULSE_LEN+WAIT_MAX.
- After `done`, IDLE is re-entered GAP_LEN cycles later. The next grant is possible on the following edge.
- Minimum transaction period: 1+PULSE_LEN+1+GAP_LEN+... = PULSE_LEN+GAP_LEN+2 cycles.
- `rst` mid-transaction: `press` and `grant` drop asynchronously, with no `done`. The pointer returns to 0.

## Test plan
- Reset values: assert `rst`, then release -> all outputs 0, state IDLE, `press` never pulses with `req`=0.
- Single request, ok: `req`=4'b0010, `fsm_count` goes 5->6 two cycles after `press` falls -> `press` high exactly 2 cycles, `grant`=0010, `done` with `result`=01, `last_id`=1, then 3 gap cycles.
- Round-robin fairness: `req`=4'b1111 held for 4 transactions -> grants 0001, 0010, 0100, 1000, then 0001. `req`=4'b1001 after granting 0 -> next grant is 1000.
- Error priority: in the same WAIT cycle, `fsm_err` 0->1 and `fsm_count` 3->4 -> `result`=10.
- Timeout and wrap: no FSM change -> `done` with `result`=11 exactly WAIT_MAX=16 cycles into WAIT. Repeat with `fsm_count` 8'hFF->8'h00 -> `result`=01.
- Reset mid-PULSE: assert `rst` while `press`=1 -> `press`/`grant` go 0 without waiting for a clock, no `done`, and the next grant after release with `req`=1111 goes to requester 0.
